// File: rtl/ibex_instr_mem_pkg.sv
// Shared types and constants for the instruction-fetch memory responder.
// Pure declarations: no logic, no latency, no flow control.
// The queue entry carries everything needed to answer one granted fetch.
package ibex_instr_mem_pkg;

    localparam int unsigned MaxLatency = 8;
    localparam int unsigned MaxOutst   = 8;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LfsrTaps = 16'hB400;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [2:0]  cnt;
    } resp_entry_t;

endpackage

// File: rtl/ibex_instr_mem_resp_fifo.sv
// In-order queue of pending fetch responses with per-entry countdown.
// Latency: entry is visible at the head the cycle after push; head_ready once its countdown is 0.
// Backpressure: none internally; the caller must not push beyond MaxOutst entries.
module ibex_instr_mem_resp_fifo
    import ibex_instr_mem_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        push,
    input  resp_entry_t push_entry,
    input  logic        pop,
    output resp_entry_t head,
    output logic        head_ready,
    output logic [3:0]  count
);

    localparam int unsigned PtrW = $clog2(MaxOutst);

    resp_entry_t          slots [MaxOutst];
    logic [PtrW-1:0]      rd_ptr;
    logic [PtrW-1:0]      wr_ptr;
    logic                 push_ok;
    logic                 pop_ok;

    assign head       = slots[rd_ptr];
    assign head_ready = (count != 4'd0) && (head.cnt == 3'd0);
    assign push_ok    = push && (count < 4'(MaxOutst));
    assign pop_ok     = pop && head_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(MaxOutst); i++) begin
                slots[i] <= '0;
            end
        end else begin
            // Every slot ages in parallel; empty slots aging is harmless
            for (int i = 0; i < int'(MaxOutst); i++) begin
                if (slots[i].cnt != 3'd0) begin
                    slots[i].cnt <= slots[i].cnt - 3'd1;
                end
            end
            if (push_ok) begin
                slots[wr_ptr] <= push_entry;
                wr_ptr        <= wr_ptr + PtrW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            count <= count + 4'(push_ok) - 4'(pop_ok);
        end
    end

endmodule

// File: rtl/ibex_instr_mem_responder.sv
// Instruction-fetch memory responder: word array, address decode, grant, in-order responses.
// Latency: rvalid exactly Latency cycles after the grant cycle; grant is combinational.
// Backpressure: gnt drops at MaxOutstanding pending; INSTR_MEM_RESP_STALL_EN adds LFSR stalls.
module ibex_instr_mem_responder
    import ibex_instr_mem_pkg::*;
#(
    parameter int unsigned MemWords       = 1024,
    parameter logic [31:0] BaseAddr       = 32'h0000_0000,
    parameter int unsigned Latency        = 1,
    parameter int unsigned MaxOutstanding = 2,
    parameter logic [15:0] LfsrSeed       = 16'hACE1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        instr_req_i,
    input  logic [31:0]                 instr_addr_i,
    output logic                        instr_gnt_o,
    output logic                        instr_rvalid_o,
    output logic [31:0]                 instr_rdata_o,
    output logic                        instr_err_o,
    input  logic                        load_we_i,
    input  logic [$clog2(MemWords)-1:0] load_addr_i,
    input  logic [31:0]                 load_wdata_i,
    output logic [3:0]                  outstanding_o,
    output logic                        busy_o
);

    localparam int unsigned AddrW      = $clog2(MemWords);
    localparam logic [32:0] RangeBytes = 33'(MemWords) << 2;

    logic [31:0]      mem [MemWords];
    logic [31:0]      offset;
    logic [AddrW-1:0] word_idx;
    logic             in_range;
    logic             addr_err;
    logic             slot_free;
    logic             stall;
    resp_entry_t      push_entry;
    resp_entry_t      head;
    logic             head_ready;
    logic             unused_bits;

    // Subtraction wraps below BaseAddr, so one unsigned compare covers both bounds
    assign offset    = instr_addr_i - BaseAddr;
    assign in_range  = {1'b0, offset} < RangeBytes;
    assign addr_err  = (instr_addr_i[1:0] != 2'b00) || !in_range;
    assign word_idx  = offset[AddrW+1:2];

    // Array read happens before the same-edge preload write lands
    assign push_entry.rdata = addr_err ? 32'h0 : mem[word_idx];
    assign push_entry.err   = addr_err;
    assign push_entry.cnt   = 3'(Latency - 1);

    always_ff @(posedge clk_i) begin
        if (load_we_i) begin
            mem[load_addr_i] <= load_wdata_i;
        end
    end

`ifdef INSTR_MEM_RESP_STALL_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= LfsrSeed;
        end else begin
            lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LfsrTaps)};
        end
    end

    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // A retirement this cycle does not free a slot until the next cycle
    assign slot_free   = outstanding_o < 4'(MaxOutstanding);
    assign instr_gnt_o = rst_ni && instr_req_i && slot_free && !stall;

    ibex_instr_mem_resp_fifo u_resp_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push       (instr_gnt_o),
        .push_entry (push_entry),
        .pop        (head_ready),
        .head       (head),
        .head_ready (head_ready),
        .count      (outstanding_o)
    );

    assign instr_rvalid_o = head_ready;
    assign instr_rdata_o  = head_ready ? head.rdata : 32'h0;
    assign instr_err_o    = head_ready && head.err;
    assign busy_o         = (outstanding_o != 4'd0);

    assign unused_bits = ^{offset, head.cnt};

endmodule

// File: tb/tb_ibex_instr_mem_responder.sv
// Bench for two responder instances (Latency 1 and 3) sharing one stimulus stream,
// checked every cycle against a due-time queue model plus directed vectors.
module tb_ibex_instr_mem_responder;

    localparam int MAXO = 2;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [31:0] addr;
    logic        load_we;
    logic [9:0]  load_addr;
    logic [31:0] load_wdata;

    logic [1:0]  gnt, rvalid, err, busy;
    logic [31:0] rdata [2];
    logic [3:0]  outst [2];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    ibex_instr_mem_responder #(.MemWords(1024), .BaseAddr(32'h0), .Latency(LAT0),
                               .MaxOutstanding(MAXO), .LfsrSeed(16'hACE1)) u_dut_l1 (
        .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req), .instr_addr_i(addr),
        .instr_gnt_o(gnt[0]), .instr_rvalid_o(rvalid[0]), .instr_rdata_o(rdata[0]),
        .instr_err_o(err[0]), .load_we_i(load_we), .load_addr_i(load_addr),
        .load_wdata_i(load_wdata), .outstanding_o(outst[0]), .busy_o(busy[0]));

    ibex_instr_mem_responder #(.MemWords(1024), .BaseAddr(32'h0), .Latency(LAT1),
                               .MaxOutstanding(MAXO), .LfsrSeed(16'hACE1)) u_dut_l3 (
        .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req), .instr_addr_i(addr),
        .instr_gnt_o(gnt[1]), .instr_rvalid_o(rvalid[1]), .instr_rdata_o(rdata[1]),
        .instr_err_o(err[1]), .load_we_i(load_we), .load_addr_i(load_addr),
        .load_wdata_i(load_wdata), .outstanding_o(outst[1]), .busy_o(busy[1]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        if (i == 3) return 32'hDEAD_BEEF;
        if (i == 4) return 32'h0;
        return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0003);
    endfunction

    function automatic logic bad_addr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'h0000_1000);
    endfunction

    // ---------------- reference model: queue of responses with absolute due cycles
    typedef struct {
        int          dut;
        int          due;
        logic [31:0] rdata;
        logic        err;
    } mexp_t;

    mexp_t       mq [$];
    logic [31:0] mem_m [1024];
    int          m_cnt [2];
    int          m_head [2];
    logic        e_gnt [2];
    logic        e_vld [2];
    logic [31:0] e_dat [2];
    logic        e_err [2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            m_cnt[d]  = 0;
            m_head[d] = -1;
            for (int i = 0; i < mq.size(); i++) begin
                if (mq[i].dut == d) begin
                    if (m_head[d] < 0) m_head[d] = i;
                    m_cnt[d]++;
                end
            end
            if (!rst_n) begin
                m_cnt[d] = 0;
                e_gnt[d] = 1'b0;
                e_vld[d] = 1'b0;
                e_dat[d] = 32'h0;
                e_err[d] = 1'b0;
            end else begin
                e_gnt[d] = req && (m_cnt[d] < MAXO);
                e_vld[d] = (m_head[d] >= 0) && (mq[m_head[d]].due == cyc);
                e_dat[d] = e_vld[d] ? mq[m_head[d]].rdata : 32'h0;
                e_err[d] = e_vld[d] && mq[m_head[d]].err;
            end
            check(d == 0 ? "l1_gnt"    : "l3_gnt",    32'(gnt[d]),    32'(e_gnt[d]));
            check(d == 0 ? "l1_rvalid" : "l3_rvalid", 32'(rvalid[d]), 32'(e_vld[d]));
            check(d == 0 ? "l1_rdata"  : "l3_rdata",  rdata[d],       e_dat[d]);
            check(d == 0 ? "l1_err"    : "l3_err",    32'(err[d]),    32'(e_err[d]));
            check(d == 0 ? "l1_outst"  : "l3_outst",  32'(outst[d]),  32'(m_cnt[d]));
            check(d == 0 ? "l1_busy"   : "l3_busy",   32'(busy[d]),   32'(m_cnt[d] != 0));
        end
        if (!rst_n) begin
            mq.delete();
        end else begin
            if (e_vld[0] && e_vld[1]) begin
                if (m_head[0] > m_head[1]) begin
                    mq.delete(m_head[0]); mq.delete(m_head[1]);
                end else begin
                    mq.delete(m_head[1]); mq.delete(m_head[0]);
                end
            end else if (e_vld[0]) begin
                mq.delete(m_head[0]);
            end else if (e_vld[1]) begin
                mq.delete(m_head[1]);
            end
            for (int d = 0; d < 2; d++) begin
                if (e_gnt[d]) begin
                    mq.push_back('{dut: d, due: cyc + (d == 0 ? LAT0 : LAT1),
                                   rdata: bad_addr(addr) ? 32'h0 : mem_m[addr[11:2]],
                                   err: bad_addr(addr)});
                end
            end
        end
        if (load_we) mem_m[load_addr] = load_wdata;
        cyc++;
    end

    // ---------------- stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy != 2'b00 && k < 100) begin
            tick();
            k++;
        end
        check("idle_timeout", 32'(busy), 32'h0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t        vecs [8];
    logic [11:0] gv, rv;
    int          k3;
    logic        got;
    int          lat_k;
    int          nvld;

    initial begin
        rst_n = 1'b0; req = 1'b1; addr = 32'h0;
        load_we = 1'b0; load_addr = '0; load_wdata = '0;

        vecs[0] = '{32'h0000_000C, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{32'h0000_0002, 32'h0,         1'b1};
        vecs[2] = '{32'h0000_1000, 32'h0,         1'b1};
        vecs[3] = '{32'h0000_0000, pat(0),        1'b0};
        vecs[4] = '{32'h0000_00FC, pat(63),       1'b0};
        vecs[5] = '{32'hFFFF_FFFC, 32'h0,         1'b1};
        vecs[6] = '{32'h0000_0023, 32'h0,         1'b1};
        vecs[7] = '{32'h0000_0FFC, 32'h0,         1'b0};

        repeat (3) tick();
        check("reset_gnt",    32'(gnt),    32'h0);
        check("reset_rvalid", 32'(rvalid), 32'h0);
        check("reset_outst",  32'(outst[1]), 32'h0);
        req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // preload words 0..63 and the top word
        for (int i = 0; i < 64; i++) begin
            load_we = 1'b1; load_addr = 10'(i); load_wdata = pat(i);
            tick();
        end
        load_addr = 10'd1023; load_wdata = 32'h0;
        tick();
        load_we = 1'b0;

        // directed vectors on the Latency=1 instance
        foreach (vecs[i]) begin
            wait_idle();
            req = 1'b1; addr = vecs[i].addr;
            got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                @(negedge clk);
                got = gnt[0];
                tick();
            end
            req = 1'b0;
            check("vec_gnt_seen", 32'(got), 32'h1);
            lat_k = 0;
            @(negedge clk);
            while (!rvalid[0] && lat_k < 20) begin
                @(negedge clk);
                lat_k++;
            end
            check("vec_latency", 32'(lat_k), 32'h0);
            check("vec_rdata", rdata[0], vecs[i].rdata);
            check("vec_err", 32'(err[0]), 32'(vecs[i].err));
            tick();
        end

        // Latency=3, MaxOutstanding=2: three held requests
        wait_idle();
        req = 1'b1; addr = 32'h0; k3 = 0; gv = '0; rv = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            gv[c] = gnt[1];
            rv[c] = rvalid[1];
            if (gnt[1]) k3++;
            tick();
            if (k3 >= 3) req = 1'b0;
            else addr = 32'(k3) * 32'd4;
        end
        check("l3_gnt_cycles",    32'(gv), 32'h013);
        check("l3_rvalid_cycles", 32'(rv), 32'h098);

        // grant and preload of the same word in one cycle
        wait_idle();
        req = 1'b1; addr = 32'h10;
        load_we = 1'b1; load_addr = 10'd4; load_wdata = 32'h1234_5678;
        @(negedge clk);
        check("rbw_gnt", 32'(gnt[0]), 32'h1);
        tick();
        req = 1'b0; load_we = 1'b0;
        @(negedge clk);
        check("rbw_old_vld", 32'(rvalid[0]), 32'h1);
        check("rbw_old_data", rdata[0], 32'h0);
        wait_idle();
        req = 1'b1; addr = 32'h10;
        tick();
        req = 1'b0;
        @(negedge clk);
        check("rbw_new_data", rdata[0], 32'h1234_5678);

        // reset pulse with two grants pending on the Latency=3 instance
        wait_idle();
        req = 1'b1; addr = 32'h14;
        tick();
        addr = 32'h18;
        tick();
        check("rst_pre_outst", 32'(outst[1]), 32'h2);
        req = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        nvld = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rvalid[1]) nvld++;
        end
        check("rst_no_rvalid", 32'(nvld), 32'h0);
        check("rst_outst", 32'(outst[1]), 32'h0);
        tick();
        req = 1'b1; addr = 32'h14;
        @(negedge clk);
        check("post_rst_gnt", 32'(gnt[1]), 32'h1);
        tick();
        req = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_rvalid", 32'(rvalid[1]), 32'h1);
        check("post_rst_rdata", rdata[1], pat(5));
        tick();

        // randomized traffic, checked by the model every cycle
        for (int c = 0; c < 800; c++) begin
            int r;
            req = ($urandom_range(0, 99) < 70);
            r = $urandom_range(0, 99);
            if (r < 85) begin
                addr = 32'($urandom_range(0, 63)) * 32'd4;
            end else begin
                case (r % 4)
                    0:       addr = 32'h0000_0002;
                    1:       addr = 32'h0000_1000;
                    2:       addr = 32'hFFFF_FFFC;
                    default: addr = (32'($urandom_range(0, 63)) * 32'd4) | 32'h1;
                endcase
            end
            load_we    = ($urandom_range(0, 99) < 20);
            load_addr  = 10'($urandom_range(0, 63));
            load_wdata = $urandom;
            tick();
        end
        req = 1'b0; load_we = 1'b0;
        wait_idle();
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
